decode_stage_fwd: RTL

Parametrised successor to the single-issue decode stage. Generates the immediate for every RV64I format and selects operands from an N-entry forwarding network, with per-source priority and x0 suppression. Adds three things the earlier stage lacked: a load-use interlock with bubble insertion, a branch-shadow FSM, and a ready/valid handshake to fetch and execute. Sits between the fetch latch (DE_*) and the EXE latch; the register file and CSR file stay outside the block.

---
 rtl/rv_decode_pkg.sv | 27 ++
 rtl/rv_imm_gen.sv | 40 ++++
 rtl/decode_stage_fwd.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV64I decode constants: major opcodes, ECALL encoding, decode FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rv_decode_pkg;

   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP32     = 7'b0111011;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;

   localparam logic [31:0] ECALL = 32'h0000_0073;

   // RUN must stay at zero: it is the reset state of the decode FSM
   typedef enum logic [0:0] {
      RUN     = 1'b0,
      BR_WAIT = 1'b1
   } dec_state_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator for every RV64I format, sign-extended to XLEN.
// Latency: purely combinational.
// Backpressure: none; output follows ir directly.
module rv_imm_gen
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 64
)(
   input  logic [31:0]     ir,
   output logic [XLEN-1:0] imm
);

   logic [6:0]  opc;
   logic        is_shift;
   logic [63:0] imm64;
   logic [63:0] imm_i;

   assign opc      = ir[6:0];
   // SLLI/SRLI/SRAI (funct3 001/101) carry a shift amount, not a signed immediate
   assign is_shift = (ir[13:12] == 2'b01);
   assign imm_i    = {{52{ir[31]}}, ir[31:20]};

   // Format select; unknown opcodes give zero so nothing stale leaks through
   always_comb begin
      imm64 = '0;
      case (opc)
         LOAD, JALR: imm64 = imm_i;
         OP_IMM:     imm64 = is_shift ? {58'd0, ir[25:20]} : imm_i;
         OP_IMM32:   imm64 = is_shift ? {59'd0, ir[24:20]} : imm_i;
         STORE:      imm64 = {{52{ir[31]}}, ir[31:25], ir[11:7]};
         BRANCH:     imm64 = {{52{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         LUI, AUIPC: imm64 = {{32{ir[31]}}, ir[31:12], 12'd0};
         JAL:        imm64 = {{44{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
         default:    imm64 = '0;
      endcase
   end

   assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/decode_stage_fwd.sv
// Decode stage: immediate gen, N-source operand forwarding, load-use interlock, branch shadow.
// Latency: accepted instruction appears on exe_* one cycle later.
// Backpressure: de_ready drops on exe_ready low, pending-load hazard, branch shadow or flush.
module decode_stage_fwd
   import rv_decode_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int NFWD        = 3,
   parameter int BR_MAX_WAIT = 15
)(
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 de_v,
   input  logic [31:0]          de_ir,
   input  logic [XLEN-1:0]      de_npc,
   output logic                 de_ready,
   input  logic [XLEN-1:0]      rf_rs1_data,
   input  logic [XLEN-1:0]      rf_rs2_data,
   input  logic [NFWD-1:0]      fwd_v,
   input  logic [5*NFWD-1:0]    fwd_rd,
   input  logic [XLEN*NFWD-1:0] fwd_data,
   input  logic [NFWD-1:0]      fwd_pending,
   input  logic                 exe_ready,
   input  logic                 flush,
   input  logic                 br_resolve,
   output logic                 exe_v,
   output logic [31:0]          exe_ir,
   output logic [XLEN-1:0]      exe_npc,
   output logic [XLEN-1:0]      exe_op1,
   output logic [XLEN-1:0]      exe_op2,
   output logic [XLEN-1:0]      exe_rs2,
   output logic                 exe_ecall,
   output logic                 br_timeout
);

   localparam int CW = $clog2(BR_MAX_WAIT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(BR_MAX_WAIT);

   logic [6:0]      opc;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            csr_imm;
   logic            rs1_used;
   logic            rs2_used;
   logic            is_ctrl;
   logic [XLEN-1:0] imm;

   assign opc      = de_ir[6:0];
   assign rs1      = de_ir[19:15];
   assign rs2      = de_ir[24:20];
   assign csr_imm  = (opc == SYSTEM) && de_ir[14];
   // CSR*I reuses the rs1 field as an immediate, so it must not raise a hazard
   assign rs1_used = !((opc == LUI) || (opc == AUIPC) || (opc == JAL) || csr_imm);
   assign rs2_used = (opc == OP) || (opc == OP32) || (opc == STORE) || (opc == BRANCH);
   assign is_ctrl  = (opc == BRANCH) || (opc == JAL) || (opc == JALR);

   rv_imm_gen #(.XLEN(XLEN)) u_imm (
      .ir  (de_ir),
      .imm (imm)
   );

   // Per-source match vectors; x0 never matches
   logic [NFWD-1:0] m1;
   logic [NFWD-1:0] m2;

   for (genvar g = 0; g < NFWD; g++) begin : g_match
      assign m1[g] = fwd_v[g] && (fwd_rd[5*g +: 5] == rs1) && (rs1 != 5'd0);
      assign m2[g] = fwd_v[g] && (fwd_rd[5*g +: 5] == rs2) && (rs2 != 5'd0);
   end

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic            rs1_pend;
   logic            rs2_pend;

   // Priority select: walk from oldest to youngest so the lowest matching index wins
   always_comb begin
      rs1_fwd  = rf_rs1_data;
      rs2_fwd  = rf_rs2_data;
      rs1_pend = 1'b0;
      rs2_pend = 1'b0;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (m1[i]) begin
            rs1_fwd  = fwd_data[XLEN*i +: XLEN];
            rs1_pend = fwd_pending[i];
         end
         if (m2[i]) begin
            rs2_fwd  = fwd_data[XLEN*i +: XLEN];
            rs2_pend = fwd_pending[i];
         end
      end
   end

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            hz;

   assign rs1_val = (rs1 == 5'd0) ? '0 : rs1_fwd;
   assign rs2_val = (rs2 == 5'd0) ? '0 : rs2_fwd;
   assign op1     = csr_imm ? XLEN'(rs1) : rs1_val;
   assign op2     = opc[5] ? rs2_val : imm;
   assign hz      = (rs1_used && rs1_pend) || (rs2_used && rs2_pend);

   dec_state_t    state;
   dec_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          live;
   logic          take;

   // live holds decode off until the first clock after reset is released
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
         live  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         live  <= 1'b1;
      end
   end

   // Next state, wait counter and acceptance; flush overrides everything
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      de_ready  = 1'b0;
      take      = 1'b0;
      if (flush) begin
         state_nxt = RUN;
         cnt_nxt   = '0;
      end else begin
         case (state)
            RUN: begin
               de_ready = live && exe_ready && !hz;
               take     = de_ready && de_v;
               if (take && is_ctrl) begin
                  state_nxt = BR_WAIT;
               end
            end
            BR_WAIT: begin
               if (br_resolve) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else if (exe_ready && (cnt != CNT_MAX)) begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign br_timeout = (cnt == CNT_MAX);

   // EXE latch: load on accept, bubble whenever EXE advances without one, hold on stall
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         exe_v     <= 1'b0;
         exe_ir    <= '0;
         exe_npc   <= '0;
         exe_op1   <= '0;
         exe_op2   <= '0;
         exe_rs2   <= '0;
         exe_ecall <= 1'b0;
      end else if (flush) begin
         exe_v <= 1'b0;
      end else if (exe_ready) begin
         exe_v <= take;
         if (take) begin
            exe_ir    <= de_ir;
            exe_npc   <= de_npc;
            exe_op1   <= op1;
            exe_op2   <= op2;
            exe_rs2   <= rs2_val;
            exe_ecall <= (de_ir == ECALL);
         end
      end
   end

endmodule
